bram_heap_pq: RTL and testbench

Parametrised BRAM-backed binary-heap priority queue. It is the next generation of the per-level BRAM tree sorter. It supports three operations: push, pop and replace-top. Operations are accepted through a valid/ready handshake, the occupancy is tracked, and the heap order (max or min) is selectable. Node storage sits in one inferred true-dual-port RAM with 1-cycle read latency, and the root is mirrored in a register for zero-latency top access.

---
 rtl/bram_heap_pq_if.sv | 20 ++
 rtl/bram_heap_pq.sv | 133 +++++++++++++
 tb/tb_bram_heap_pq.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_heap_pq_if.sv
// bram_heap_pq_if: request handshake and status bundle between a client and the heap priority queue.
interface bram_heap_pq_if #(
   parameter int DATA_WIDTH = 32,
   parameter int TREE_DEPTH = 4
);
   logic                  i_valid;
   logic [1:0]            i_op;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  o_ready;
   logic [DATA_WIDTH-1:0] o_top;
   logic                  o_top_valid;
   logic [TREE_DEPTH-1:0] o_count;
   logic                  o_full;
   logic                  o_empty;
   logic                  o_err;
   modport master (output i_valid, i_op, i_data,
                   input  o_ready, o_top, o_top_valid, o_count, o_full, o_empty, o_err);
   modport slave  (input  i_valid, i_op, i_data,
                   output o_ready, o_top, o_top_valid, o_count, o_full, o_empty, o_err);
endinterface

// File: rtl/bram_heap_pq.sv
// bram_heap_pq: binary-heap priority queue (push/pop/replace-top) over a dual-port RAM,
// root mirrored in top_q so the top item is visible with no read latency.
module bram_heap_pq #(
   parameter int DATA_WIDTH = 32,
   parameter int TREE_DEPTH = 4,
   parameter int MAX_HEAP   = 1
) (
   input logic           clk,
   input logic           rst,
   bram_heap_pq_if.slave bus
);
   localparam int AW = TREE_DEPTH;
   localparam logic [AW-1:0] CAP = AW'((1 << TREE_DEPTH) - 1);
   typedef enum logic [2:0] {IDLE, POP_FETCH, SD_READ, SD_CMP, SU_READ, SU_CMP} state_t;
   state_t state, state_n;
   logic [DATA_WIDTH-1:0] mem [0:(1 << AW)-1];
   logic [DATA_WIDTH-1:0] cur, cur_n, top_q, rd_a, rd_b, wd, best;
   logic [AW-1:0] idx, idx_n, count, count_n, addr_a, addr_b, parent, best_idx;
   logic [AW:0] lc, rc;
   logic we, err_q, err_n, l_ok, r_ok, pick_r, ready, accept, full, empty, push_ok;

   function automatic logic beats(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
      return MAX_HEAP != 0 ? a > b : a < b;
   endfunction

   assign full     = count == CAP;
   assign empty    = count == '0;
   assign ready    = state == IDLE && !rst;
   assign accept   = bus.i_valid && ready;
   assign push_ok  = (bus.i_op == 2'b00 || (bus.i_op == 2'b10 && empty)) && !full;
   assign lc       = {idx, 1'b1};
   assign rc       = {idx, 1'b0} + (AW+1)'(2);
   assign parent   = (idx - AW'(1)) >> 1;
   assign l_ok     = lc < {1'b0, count};
   assign r_ok     = rc < {1'b0, count};
   assign pick_r   = r_ok && beats(rd_b, rd_a);
   assign best     = pick_r ? rd_b : rd_a;
   assign best_idx = pick_r ? rc[AW-1:0] : lc[AW-1:0];

   always_comb begin
      state_n = state;
      cur_n   = cur;
      idx_n   = idx;
      count_n = count;
      err_n   = 1'b0;
      we      = 1'b0;
      wd      = cur;
      addr_a  = idx;
      addr_b  = rc[AW-1:0];
      case (state)
         IDLE: if (accept) begin
            if (push_ok) begin
               cur_n   = bus.i_data;
               idx_n   = count;
               count_n = count + AW'(1);
               state_n = SU_READ;
            end else if (bus.i_op == 2'b01 && !empty) begin
               count_n = count - AW'(1);
               addr_a  = count - AW'(1);
               state_n = POP_FETCH;
            end else if (bus.i_op == 2'b10) begin
               cur_n   = bus.i_data;
               idx_n   = '0;
               state_n = SD_READ;
            end else err_n = 1'b1;
         end
         POP_FETCH: begin
            cur_n   = rd_a;
            idx_n   = '0;
            state_n = count == '0 ? IDLE : SD_READ;
         end
         SD_READ: begin
            addr_a  = lc[AW-1:0];
            state_n = SD_CMP;
         end
         // missing children are never chosen, so stale RAM beyond count is harmless
         SD_CMP: begin
            we = 1'b1;
            if (l_ok && beats(best, cur)) begin
               wd      = best;
               idx_n   = best_idx;
               state_n = SD_READ;
            end else state_n = IDLE;
         end
         SU_READ: begin
            we      = idx == '0;
            addr_a  = idx == '0 ? idx : parent;
            state_n = idx == '0 ? IDLE : SU_CMP;
         end
         SU_CMP: begin
            we = 1'b1;
            if (beats(cur, rd_a)) begin
               wd      = rd_a;
               idx_n   = parent;
               state_n = SU_READ;
            end else state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (we) mem[addr_a] <= wd;
      rd_a <= mem[addr_a];
      rd_b <= mem[addr_b];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cur   <= '0;
         idx   <= '0;
         count <= '0;
         top_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         cur   <= cur_n;
         idx   <= idx_n;
         count <= count_n;
         err_q <= err_n;
         if (we && addr_a == '0) top_q <= wd;
      end
   end

   assign bus.o_ready     = ready;
   assign bus.o_top       = top_q;
   assign bus.o_top_valid = ready && !empty;
   assign bus.o_count     = count;
   assign bus.o_full      = full;
   assign bus.o_empty     = empty;
   assign bus.o_err       = err_q;
endmodule

// File: tb/tb_bram_heap_pq.sv
// tb_bram_heap_pq: scenario tasks against a max-heap and a min-heap instance, with a
// queue model supplying the expected popped item for every pop.
module tb_bram_heap_pq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic valid = 1'b0;
   logic sel_min = 1'b0;
   logic [1:0] op = 2'b00;
   logic [31:0] data = '0;
   logic ready, top_valid, full, empty, err, acc_valid;
   logic [31:0] top, acc_top;
   logic [3:0] count;
   logic [31:0] model[$];
   logic [31:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   bram_heap_pq_if #(.DATA_WIDTH(32), .TREE_DEPTH(4)) bm ();
   bram_heap_pq_if #(.DATA_WIDTH(32), .TREE_DEPTH(4)) bn ();

   bram_heap_pq #(.DATA_WIDTH(32), .TREE_DEPTH(4), .MAX_HEAP(1)) dut_max (.clk(clk), .rst(rst), .bus(bm));
   bram_heap_pq #(.DATA_WIDTH(32), .TREE_DEPTH(4), .MAX_HEAP(0)) dut_min (.clk(clk), .rst(rst), .bus(bn));

   assign bm.i_valid = valid && !sel_min;
   assign bm.i_op    = op;
   assign bm.i_data  = data;
   assign bn.i_valid = valid && sel_min;
   assign bn.i_op    = op;
   assign bn.i_data  = data;
   assign ready      = sel_min ? bn.o_ready : bm.o_ready;
   assign top        = sel_min ? bn.o_top : bm.o_top;
   assign top_valid  = sel_min ? bn.o_top_valid : bm.o_top_valid;
   assign count      = sel_min ? bn.o_count : bm.o_count;
   assign full       = sel_min ? bn.o_full : bm.o_full;
   assign empty      = sel_min ? bn.o_empty : bm.o_empty;
   assign err        = sel_min ? bn.o_err : bm.o_err;

   always #5 clk = ~clk;

   function automatic logic [31:0] model_take();
      int b = 0;
      logic [31:0] v;
      for (int i = 1; i < model.size(); i++)
         if (sel_min ? model[i] < model[b] : model[i] > model[b]) b = i;
      v = model[b];
      model.delete(b);
      return v;
   endfunction

   task automatic do_op(input logic [1:0] o, input logic [31:0] d, output int busy);
      int n = 0;
      while (ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      acc_top   = top;
      acc_valid = top_valid;
      valid = 1'b1;
      op    = o;
      data  = d;
      @(posedge clk); #1;
      valid = 1'b0;
      busy  = 0;
      while (ready !== 1'b1 && busy < 100) begin @(posedge clk); #1; busy++; end
      if (n >= 100 || busy >= 100) begin
         checks++; errors++;
         $display("FAIL op_timeout: op=%0d ready=%0b, required 1 within 100 cycles", o, ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bm.o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %0b required 0", bm.o_ready); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({ready, empty, full, top_valid, err} !== 5'b11000) begin
         errors++; $display("FAIL reset_flags: ready/empty/full/top_valid/err got %b required 11000", {ready, empty, full, top_valid, err});
      end
      checks++;
      if (count !== 4'd0 || top !== 32'd0) begin errors++; $display("FAIL reset_count_top: count=%0d top=%0d required 0 0", count, top); end
   endtask

   task automatic test_push();
      int busy;
      int eb[4] = '{1, 2, 3, 2};
      logic [31:0] v[4] = '{5, 3, 9, 1};
      for (int i = 0; i < 4; i++) begin
         do_op(2'b00, v[i], busy);
         model.push_back(v[i]);
         checks++;
         if (busy != eb[i]) begin errors++; $display("FAIL push_latency[%0d]: got %0d required %0d", i, busy, eb[i]); end
      end
      checks++;
      if (top !== 32'd9 || count !== 4'd4 || top_valid !== 1'b1) begin
         errors++; $display("FAIL push_result: top=%0d count=%0d valid=%0b required 9 4 1", top, count, top_valid);
      end
   endtask

   task automatic test_pop();
      int busy;
      logic [31:0] e;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(model_take());
         do_op(2'b01, 0, busy);
         e = exp_q.pop_front();
         checks++;
         if (acc_valid !== 1'b1 || acc_top !== e) begin
            errors++; $display("FAIL pop_item[%0d]: top=%0d valid=%0b required %0d", i, acc_top, acc_valid, e);
         end
         if (i == 0) begin
            checks++;
            if (busy != 5) begin errors++; $display("FAIL pop_latency: got %0d required 5", busy); end
         end
      end
      checks++;
      if (empty !== 1'b1 || top_valid !== 1'b0 || busy != 1) begin
         errors++; $display("FAIL pop_empty: empty=%0b valid=%0b busy=%0d required 1 0 1", empty, top_valid, busy);
      end
      do_op(2'b01, 0, busy);
      checks++;
      if (err !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL pop_underflow: err=%0b count=%0d required 1 0", err, count); end
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: err=%0b required 0", err); end
   endtask

   task automatic test_replace();
      int busy;
      logic [31:0] e;
      logic [31:0] v[4] = '{9, 5, 3, 1};
      for (int i = 0; i < 4; i++) begin do_op(2'b00, v[i], busy); model.push_back(v[i]); end
      void'(model_take());
      model.push_back(4);
      do_op(2'b10, 4, busy);
      checks++;
      if (top !== 32'd5 || count !== 4'd4 || busy != 4) begin
         errors++; $display("FAIL replace: top=%0d count=%0d busy=%0d required 5 4 4", top, count, busy);
      end
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(model_take());
         do_op(2'b01, 0, busy);
         e = exp_q.pop_front();
         checks++;
         if (acc_top !== e) begin errors++; $display("FAIL replace_pop[%0d]: got %0d required %0d", i, acc_top, e); end
      end
   endtask

   task automatic test_full();
      int busy;
      int worst = 0;
      logic [31:0] d, t, e;
      for (int i = 0; i < 15; i++) begin
         d = $urandom_range(0, 255);
         do_op(2'b00, d, busy);
         model.push_back(d);
      end
      checks++;
      if (full !== 1'b1 || count !== 4'd15) begin errors++; $display("FAIL fill: full=%0b count=%0d required 1 15", full, count); end
      t = top;
      do_op(2'b00, 32'd999, busy);
      checks++;
      if (err !== 1'b1 || top !== t || count !== 4'd15) begin
         errors++; $display("FAIL overflow: err=%0b top=%0d count=%0d required 1 %0d 15", err, top, count, t);
      end
      for (int i = 0; i < 15; i++) begin
         exp_q.push_back(model_take());
         do_op(2'b01, 0, busy);
         e = exp_q.pop_front();
         if (busy > worst) worst = busy;
         checks++;
         if (acc_top !== e) begin errors++; $display("FAIL drain_pop[%0d]: got %0d required %0d", i, acc_top, e); end
      end
      checks++;
      if (worst > 9 || empty !== 1'b1) begin errors++; $display("FAIL drain: worst_busy=%0d empty=%0b required <=9 1", worst, empty); end
   endtask

   task automatic test_min();
      int busy;
      logic [31:0] e;
      logic [31:0] v[3] = '{7, 7, 2};
      sel_min = 1'b1;
      for (int i = 0; i < 3; i++) begin do_op(2'b00, v[i], busy); model.push_back(v[i]); end
      checks++;
      if (top !== 32'd2) begin errors++; $display("FAIL min_top: got %0d required 2", top); end
      do_op(2'b11, 32'd1, busy);
      checks++;
      if (err !== 1'b1 || busy != 0 || count !== 4'd3 || top !== 32'd2) begin
         errors++; $display("FAIL reserved_op: err=%0b busy=%0d count=%0d top=%0d required 1 0 3 2", err, busy, count, top);
      end
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(model_take());
         do_op(2'b01, 0, busy);
         e = exp_q.pop_front();
         checks++;
         if (acc_top !== e) begin errors++; $display("FAIL min_pop[%0d]: got %0d required %0d", i, acc_top, e); end
      end
      sel_min = 1'b0;
   endtask

   task automatic test_reset_mid();
      int busy;
      logic [31:0] v[4] = '{9, 5, 3, 1};
      for (int i = 0; i < 4; i++) do_op(2'b00, v[i], busy);
      valid = 1'b1;
      op    = 2'b10;
      data  = 32'd0;
      @(posedge clk); #1;
      valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL midop_ready: got %0b required 0", ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      model.delete();
      #1;
      checks++;
      if (ready !== 1'b1 || count !== 4'd0 || empty !== 1'b1) begin
         errors++; $display("FAIL midop_reset: ready=%0b count=%0d empty=%0b required 1 0 1", ready, count, empty);
      end
      do_op(2'b00, 32'd8, busy);
      checks++;
      if (top !== 32'd8 || count !== 4'd1) begin errors++; $display("FAIL post_reset_push: top=%0d count=%0d required 8 1", top, count); end
   endtask

   initial begin
      test_reset();
      test_push();
      test_pop();
      test_replace();
      test_full();
      test_min();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
